// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one registered ALU among N_REQ requesters.
// Grants one request per clock and returns the ALU result one cycle later.
module alu_rr_arbiter #(
  parameter int WIDTH = 8,
  parameter int N_REQ = 4,
  parameter int ID_W  = 3
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [N_REQ-1:0]       req_valid_i,
  output logic [N_REQ-1:0]       req_ready_o,
  input  logic [N_REQ*WIDTH-1:0] req_first_i,
  input  logic [N_REQ*WIDTH-1:0] req_second_i,
  input  logic [N_REQ*3-1:0]     req_opcode_i,
  output logic [WIDTH-1:0]       alu_first_o,
  output logic [WIDTH-1:0]       alu_second_o,
  output logic [2:0]             alu_opcode_o,
  input  logic [WIDTH-1:0]       alu_result_i,
  output logic [N_REQ-1:0]       rsp_valid_o,
  output logic [ID_W-1:0]        rsp_id_o,
  output logic [WIDTH-1:0]       rsp_result_o,
  output logic [15:0]            issued_cnt_o
);

  logic [ID_W-1:0]  r_ptr;
  logic [N_REQ-1:0] r_rsp_valid;
  logic [ID_W-1:0]  r_rsp_id;
  logic [15:0]      r_cnt;

  logic [N_REQ-1:0] w_hi;
  logic [N_REQ-1:0] w_sel;
  logic [N_REQ-1:0] w_gnt_oh;
  logic [ID_W-1:0]  w_gnt;
  logic             w_found;
  logic [ID_W-1:0]  w_ptr_nxt;

  // Requests at or above ptr take precedence; if none, wrap to the lowest valid index.
  always_comb begin
    w_hi     = '0;
    w_gnt_oh = '0;
    w_gnt    = '0;
    w_found  = 1'b0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      w_hi[k] = req_valid_i[k] && (ID_W'(k) >= r_ptr);
    end
    w_sel = (|w_hi) ? w_hi : req_valid_i;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (w_sel[k] && !w_found) begin
        w_found     = 1'b1;
        w_gnt       = ID_W'(k);
        w_gnt_oh[k] = 1'b1;
      end
    end
    if (rst_i) begin
      w_found  = 1'b0;
      w_gnt_oh = '0;
    end
  end

  always_comb begin
    alu_first_o  = '0;
    alu_second_o = '0;
    alu_opcode_o = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (w_gnt_oh[k]) begin
        alu_first_o  = req_first_i[k*WIDTH +: WIDTH];
        alu_second_o = req_second_i[k*WIDTH +: WIDTH];
        alu_opcode_o = req_opcode_i[k*3 +: 3];
      end
    end
  end

  assign req_ready_o = w_gnt_oh;
  assign w_ptr_nxt   = (w_gnt == ID_W'(N_REQ - 1)) ? '0 : w_gnt + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ptr       <= '0;
      r_rsp_valid <= '0;
      r_rsp_id    <= '0;
      r_cnt       <= '0;
    end else if (w_found) begin
      r_ptr       <= w_ptr_nxt;
      r_rsp_valid <= w_gnt_oh;
      r_rsp_id    <= w_gnt;
      r_cnt       <= r_cnt + 16'd1;
    end else begin
      r_rsp_valid <= '0;
    end
  end

  assign rsp_valid_o  = r_rsp_valid;
  assign rsp_id_o     = r_rsp_id;
  assign rsp_result_o = alu_result_i;
  assign issued_cnt_o = r_cnt;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Bench for alu_rr_arbiter: directed plan steps followed by random traffic,
// checked against a queue-free per-requester reference model and a stub registered ALU.
module tb_alu_rr_arbiter;
  localparam int W = 8;
  localparam int N = 4;
  localparam int IDW = 3;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_first;
  logic [N*W-1:0] req_second;
  logic [N*3-1:0] req_opcode;
  logic [W-1:0]   alu_first, alu_second, alu_res;
  logic [2:0]     alu_opcode;
  logic [N-1:0]   rsp_valid;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0]   rsp_result;
  logic [15:0]    issued_cnt;

  always #5 clk = ~clk;

  alu_rr_arbiter #(.WIDTH(W), .N_REQ(N), .ID_W(IDW)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_first_i(req_first), .req_second_i(req_second), .req_opcode_i(req_opcode),
    .alu_first_o(alu_first), .alu_second_o(alu_second), .alu_opcode_o(alu_opcode),
    .alu_result_i(alu_res),
    .rsp_valid_o(rsp_valid), .rsp_id_o(rsp_id), .rsp_result_o(rsp_result),
    .issued_cnt_o(issued_cnt)
  );

  function automatic logic [W-1:0] alu_f(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [2:0] op);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return a + b;
      3'd3:    return a - b;
      3'd4:    return a ^ b;
      default: return a;
    endcase
  endfunction

  // Stand-in for the shared alu_register: result captured at the clock edge.
  always_ff @(posedge clk) begin
    if (rst) alu_res <= '0;
    else     alu_res <= alu_f(alu_first, alu_second, alu_opcode);
  end

  // Requester-side state and reference model
  logic [N-1:0] v;
  logic [W-1:0] fa [N];
  logic [W-1:0] sa [N];
  logic [2:0]   op [N];
  int           m_ptr;
  int unsigned  m_cnt;
  logic [N-1:0] m_rv;
  int           m_rid;
  logic [W-1:0] m_res;
  int           last_g;
  int           checks = 0;
  int           errors = 0;
  int           grants [8];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      req_valid[k]          = v[k];
      req_first[k*W +: W]   = fa[k];
      req_second[k*W +: W]  = sa[k];
      req_opcode[k*3 +: 3]  = op[k];
    end
  endtask

  task automatic set_req(input int k, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [2:0] o);
    v[k] = 1'b1; fa[k] = a; sa[k] = b; op[k] = o;
  endtask

  // One clock: checks the grant path before the edge and the registered outputs after it.
  task automatic cycle();
    int g;
    logic [N-1:0] exp_rdy;
    drive();
    #1;
    g = -1;
    if (!rst) begin
      for (int i = 0; i < N; i++) begin
        int j;
        j = (m_ptr + i) % N;
        if (g < 0 && v[j]) g = j;
      end
    end
    exp_rdy = (g < 0) ? '0 : N'(1 << g);
    chk("ready", 32'(req_ready), 32'(exp_rdy));
    chk("alu_first",  32'(alu_first),  (g < 0) ? 32'd0 : 32'(fa[g]));
    chk("alu_second", 32'(alu_second), (g < 0) ? 32'd0 : 32'(sa[g]));
    chk("alu_opcode", 32'(alu_opcode), (g < 0) ? 32'd0 : 32'(op[g]));
    last_g = g;
    @(posedge clk);
    if (rst) begin
      m_ptr = 0; m_cnt = 0; m_rv = '0; m_rid = 0;
    end else if (g >= 0) begin
      m_ptr = (g + 1) % N;
      m_cnt = (m_cnt + 1) % 65536;
      m_rv  = N'(1 << g);
      m_rid = g;
      m_res = alu_f(fa[g], sa[g], op[g]);
      v[g]  = 1'b0;
    end else begin
      m_rv = '0;
    end
    #1;
    chk("rsp_valid", 32'(rsp_valid), 32'(m_rv));
    chk("rsp_id", 32'(rsp_id), 32'(m_rid));
    chk("issued_cnt", 32'(issued_cnt), m_cnt);
    if (m_rv != '0) chk("rsp_result", 32'(rsp_result), 32'(m_res));
    @(negedge clk);
  endtask

  initial begin
    m_ptr = 0; m_cnt = 0; m_rv = '0; m_rid = 0; m_res = '0;
    rst = 1'b1;
    v = '0;
    for (int k = 0; k < N; k++) set_req(k, W'(k + 1), W'(k + 5), 3'd2);
    drive();
    @(negedge clk);

    // Reset held with every requester valid
    for (int i = 0; i < 2; i++) begin
      cycle();
      chk("rst_ready", 32'(req_ready), 32'd0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("rst_cnt", 32'(issued_cnt), 32'd0);
    end
    rst = 1'b0;

    // Fairness: all valid for 8 cycles, re-requesting right after acceptance
    for (int i = 0; i < 8; i++) begin
      for (int k = 0; k < N; k++)
        if (!v[k]) set_req(k, W'($urandom), W'($urandom), 3'($urandom_range(0, 7)));
      cycle();
      grants[i] = last_g;
    end
    for (int i = 0; i < 8; i++) chk("rr_order", 32'(grants[i]), 32'(i % N));
    chk("rr_cnt", 32'(issued_cnt), 32'd8);

    // Single add from requester 2
    v = '0;
    set_req(2, 8'h12, 8'h34, 3'b010);
    cycle();
    chk("add_valid", 32'(rsp_valid), 32'h4);
    chk("add_id", 32'(rsp_id), 32'd2);
    chk("add_result", 32'(rsp_result), 32'h46);

    // Overflow pass-through on consecutive cycles
    set_req(1, 8'hFF, 8'h01, 3'b010);
    cycle();
    chk("ovf1_id", 32'(rsp_id), 32'd1);
    chk("ovf1_result", 32'(rsp_result), 32'h00);
    set_req(3, 8'h80, 8'h7F, 3'b010);
    cycle();
    chk("ovf2_id", 32'(rsp_id), 32'd3);
    chk("ovf2_result", 32'(rsp_result), 32'hFF);

    // Pointer skip: ptr wrapped to 0; grant 0 moves it to 1, lone requester 0 still wins
    set_req(0, 8'h05, 8'h06, 3'b010);
    cycle();
    set_req(0, 8'h07, 8'h08, 3'b000);
    cycle();
    chk("skip_id", 32'(rsp_id), 32'd0);
    chk("skip_valid", 32'(rsp_valid), 32'h1);
    set_req(0, 8'h11, 8'h22, 3'b001);
    set_req(1, 8'h33, 8'h44, 3'b100);
    cycle();
    chk("skip_ptr1_id", 32'(rsp_id), 32'd1);
    v = '0;

    // Reset rising while a request is presented
    set_req(3, 8'h09, 8'h0A, 3'b010);
    rst = 1'b1;
    cycle();
    chk("midrst_valid", 32'(rsp_valid), 32'd0);
    rst = 1'b0;
    for (int k = 0; k < N; k++) set_req(k, W'(k), W'(k), 3'd1);
    cycle();
    chk("midrst_ptr0", 32'(rsp_id), 32'd0);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < N; k++)
        if (!v[k] && $urandom_range(0, 1) == 1)
          set_req(k, W'($urandom), W'($urandom), 3'($urandom_range(0, 7)));
      rst = ($urandom_range(0, 39) == 0);
      cycle();
    end
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_rr_arbiter.md
# alu_rr_arbiter

Round-robin arbiter that time-shares one `alu_register` instance among `N_REQ` requesters. Each requester offers an operation (two operands plus opcode) with a valid/ready handshake. The arbiter grants at most one request per clock and steers that request's operands onto the ALU. One cycle later it returns the registered ALU result to the winner, tagged with the winner's index. It sits between the requesting engines and the single `alu_register`, and drives all of that instance's inputs.

## Interface
- `WIDTH`, 8: operand and result width; matches the `alu_register` `WIDTH`.
- `N_REQ`, 4: number of requesters; legal range 2..8.
- `ID_W`, 3: width of the requester index; must be ≥ clog2(N_REQ).
- `clk_i` in 1: single clock; all state updates on the rising edge.
- `rst_i` in 1: synchronous, active-high reset; also routed to the `alu_register`.
- `req_valid_i` in N_REQ: request valid, one bit per requester.
- `req_ready_o` out N_REQ: grant/accept; at most one bit set per cycle.
- `req_first_i` in N_REQ*WIDTH: packed first operands; requester k occupies bits [k*WIDTH +: WIDTH].
- `req_second_i` in N_REQ*WIDTH: packed second operands, same packing.
- `req_opcode_i` in N_REQ*3: packed 3-bit opcodes.
- `alu_first_o` out WIDTH: operand driven to the `alu_register` `first_i`.
- `alu_second_o` out WIDTH: operand driven to the `alu_register` `second_i`.
- `alu_opcode_o` out 3: opcode driven to the `alu_register` `opcode_i`.
- `alu_result_i` in WIDTH: the `alu_register` `result_o`.
- `rsp_valid_o` out N_REQ: one-hot response strobe, one cycle wide.
- `rsp_id_o` out ID_W: index of the requester being answered.
- `rsp_result_o` out WIDTH: response data (= `alu_result_i`).
- `issued_cnt_o` out 16: count of accepted operations; wraps at 0xFFFF.

## Operation
- **Priority pointer `ptr`** (ID_W bits)
  - Search order is ptr, ptr+1, …, N_REQ-1, 0, …, ptr-1.
  - The first requester with `req_valid_i` set wins (grant index g).
- **Grant path** (combinational, same cycle as valid)
  - `req_ready_o` is the one-hot of g.
  - `alu_*_o` carry requester g's first, second and opcode fields.
  - If no request is valid: `req_ready_o` = 0 and `alu_*_o` = 0.
- **Handshake rules**
  - A request is accepted when `req_valid_i[k] && req_ready_o[k]`.
  - A requester holds valid and data stable until accepted.
  - `req_valid_i` must not depend on `req_ready_o`.
  - A requester may re-request in the cycle after acceptance.
- **Pointer update on acceptance**
  - ptr ← g+1, wrapping to 0 after N_REQ-1.
  - No acceptance: ptr holds.
- **Response registers, on acceptance**
  - `rsp_valid_o` ← onehot(g).
  - `rsp_id_o` ← g.
- **Response registers, otherwise**
  - `rsp_valid_o` ← 0.
  - `rsp_id_o` holds its last value.
- **Response data**
  - `rsp_result_o` = `alu_result_i` (pass-through).
  - It is meaningful only while `rsp_valid_o` ≠ 0.
- **Response acceptance**: responses are unconditionally accepted; there is no response backpressure.
- **`issued_cnt_o`**: increments by 1 per acceptance, modulo 2^16.
- **Arithmetic**: the arbiter performs none. Width and overflow behaviour are those of the `alu_register` (e.g. opcode 010 = add, modulo 2^WIDTH).

## Timing
- Throughput: one accepted operation per clock. Back-to-back issue is supported, to the same or different requesters.
- Latency: an operation accepted in cycle t has `rsp_valid_o` and `rsp_result_o` valid in cycle t+1.
  - The `alu_register` captures at the end of cycle t; its result is visible in t+1.
- Reset values (in the cycle after `rst_i` is sampled high):
  - `rsp_valid_o` = 0, `rsp_id_o` = 0, `ptr` = 0, `issued_cnt_o` = 0.
  - `req_ready_o` = 0 while `rst_i` is high, regardless of valids.
- Reset mid-operation: an operation accepted in the cycle that `rst_i` rises produces no response. Nothing is accepted while `rst_i` = 1.
- Simultaneous requests: exactly one is granted. Each continuously requesting requester is served within N_REQ cycles (no starvation).
- Pointer wrap: a grant to N_REQ-1 sets ptr = 0.
- Counter wrap: 0xFFFF + 1 = 0x0000, with no side effects.
- Single requester: a requester that is the only one valid is granted every cycle, whatever the value of ptr.

## Test plan
- **Reset**
  - Stimulus: assert `rst_i` for 2 cycles with all `req_valid_i` = 1.
  - Required: `req_ready_o` = 0; `rsp_valid_o` = 0; `issued_cnt_o` = 0.
  - Then: first cycle after release, requester 0 is granted.
- **Single add**
  - Stimulus: requester 2 issues first = 0x12, second = 0x34, opcode = 010.
  - Required: `req_ready_o` = 0100 in the same cycle.
  - Next cycle: `rsp_valid_o` = 0100, `rsp_id_o` = 2, `rsp_result_o` = 0x46.
- **Round-robin fairness**
  - Stimulus: all 4 requesters valid for 8 cycles.
  - Required: grant order 0,1,2,3,0,1,2,3; `issued_cnt_o` = 8.
  - Required: each response id equals the previous cycle's grant.
- **Overflow pass-through**
  - Stimulus: requester 1 issues 0xFF + 0x01 (opcode 010).
  - Then: requester 3 issues 0x80 + 0x7F in the next cycle.
  - Required: responses 0x00 (id 1), then 0xFF (id 3), on consecutive cycles.
- **Reset mid-flight**
  - Stimulus: a request is accepted in the same cycle that `rst_i` rises.
  - Required: no `rsp_valid_o` pulse follows; `ptr` = 0 after reset.
- **Pointer skip**
  - Stimulus: with ptr = 1, only requester 0 is valid.
  - Required: requester 0 is granted and ptr becomes 1.
